sdram_stream_scheduler: RTL
===========================

Name: sdram_stream_scheduler

Overview:
- Sequences the team's SDR SDRAM controller (143 MHz domain) through three phases:
  - power-up wait, then init handshake;
  - one-shot frame fill from an upstream pixel source;
  - continuous cyclic frame readout into a downstream line FIFO.
- Owns the controller's start / write-mode / read-mode inputs.
- Throttles readout using FIFO-level watermarks with hysteresis.
- Tags the first word of every frame.

Parameters:
- DATA_WIDTH, 16, SDRAM word width.
- FRAME_WORDS, 76800, words per frame. Must equal the controller's cols×rows product and be a multiple of 8.
- PWRUP_CYC, 28600, NOP wait before start (200 us at 7 ns).
- LEVEL_W, 10, width of FIFO level input.
- FIFO_DEPTH, 512, downstream FIFO capacity in words.
- HIGH_WM, 480, level at or above which read mode drops. Required: HIGH_WM <= FIFO_DEPTH-16.
- LOW_WM, 256, level at or below which read mode re-asserts. Required: LOW_WM < HIGH_WM.

Ports:
- clk  in  1  system clock (same clock as the SDRAM controller)
- rst_n  in  1  asynchronous active-low reset
- sdram_start  out  1  to controller start
- sdram_wr_mode  out  1  to controller enable_write_mode
- sdram_rd_mode  out  1  to controller enable_read_mode
- sdram_init_done  in  1  from controller sdram_init_done
- sdram_tx_req  in  1  from controller enable_transmitter; one write beat per high cycle
- sdram_tx_data  out  DATA_WIDTH  to controller incoming_data
- sdram_rx_valid  in  1  from controller enable_receiver
- sdram_rx_data  in  DATA_WIDTH  from controller outgoing_data
- src_ready  out  1  pixel consumed from source this cycle
- src_data  in  DATA_WIDTH  current source pixel
- fifo_wr_en  out  1  write strobe to line FIFO
- fifo_wr_data  out  DATA_WIDTH  FIFO write data
- fifo_level  in  LEVEL_W  FIFO occupancy
- sof  out  1  high with fifo_wr_en on frame word 0
- fill_done  out  1  frame fully written (sticky)
- overflow  out  1  sticky: rx beat arrived while fifo_level==FIFO_DEPTH

Behaviour:
- Clock and reset:
  - One clock.
  - rst_n is asynchronous assert, synchronous deassert inside the block.
  - Reset is honoured in any state and aborts any activity.
- Reset values:
  - state=PWRUP; all outputs 0; sdram_tx_data=0.
  - Counters cleared: pwr_cnt, wr_cnt, rd_cnt.
  - rd_gate=1.
- FSM states:
  - PWRUP: pwr_cnt increments each cycle. When pwr_cnt==PWRUP_CYC-1, go to INIT.
  - INIT: sdram_start=1 (registered). When sdram_init_done=1, go to FILL and drop sdram_start.
  - FILL: sdram_wr_mode=1.
    - Each cycle with sdram_tx_req=1: sdram_tx_data=src_data combinationally, src_ready=1, wr_cnt++.
    - On the beat where wr_cnt==FRAME_WORDS-1: next cycle sdram_wr_mode=0, fill_done=1, go to STREAM.
  - STREAM: sdram_rd_mode = rd_gate.
    - rd_gate clears when fifo_level>=HIGH_WM.
    - rd_gate sets when fifo_level<=LOW_WM.
    - Between the two watermarks, rd_gate holds its value.
    - Registered: 1-cycle lag.
  - STREAM is terminal until reset.
- Write beats outside FILL: if sdram_tx_req=1 in any other state, src_ready=0 and sdram_tx_data=0; the beat is not counted.
- Read path:
  - In STREAM, each sdram_rx_valid=1 cycle produces fifo_wr_en=1 and fifo_wr_data=sdram_rx_data next cycle (1-cycle registered latency).
  - rd_cnt wraps FRAME_WORDS-1 -> 0.
  - sof=1 on the output cycle whose rd_cnt==0.
  - An rx beat while fifo_level==FIFO_DEPTH is dropped (fifo_wr_en=0), but rd_cnt still advances and overflow sets.
  - rx_valid outside STREAM is ignored and not counted.
- In-flight bursts: dropping sdram_rd_mode never truncates a burst already started; all 8 beats are accepted. Watermark headroom covers this.
- Counter widths: wr_cnt and rd_cnt are $clog2(FRAME_WORDS) bits; pwr_cnt is $clog2(PWRUP_CYC) bits.
- Simultaneous fifo_level>=HIGH_WM and <=LOW_WM cannot occur given the parameter constraints.

Test Plan:
- Reset check: PWRUP_CYC=20. Hold rst_n=0, then release. All outputs 0; sdram_start rises exactly 20 cycles after release; it stays high until init_done, then falls the cycle after.
- Frame fill: FRAME_WORDS=64. Drive 8 tx_req bursts of 8 with src_data=index. src_ready pulses 64 times; sdram_tx_data tracks src_data; fill_done=1 and sdram_wr_mode=0 one cycle after the 64th beat. A 65th tx_req gives src_ready=0.
- Watermark hysteresis: HIGH_WM=480, LOW_WM=256. Sweep fifo_level 0->480: rd_mode drops 1 cycle after level hits 480. Sweep back to 300: rd_mode stays 0. At 256, rd_mode re-asserts the next cycle.
- Frame tagging: FRAME_WORDS=64, 130 rx beats. fifo_wr_en 130 times, each 1 cycle after rx_valid; sof on beats 0, 64 and 128 only.
- Overflow: hold fifo_level=512 during a burst. No fifo_wr_en for those beats; overflow=1 and sticky; rd_cnt alignment (next sof) preserved.
- Reset mid-fill: assert rst_n=0 after 20 beats. Outputs clear asynchronously; a full re-run requires 64 beats again.

Source files
------------

// File: rtl/sdram_stream_scheduler_if.sv
//------------------------------------------------------------------------------
// sdram_stream_scheduler_if : SDRAM controller / pixel source / line FIFO bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sdram_stream_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEVEL_W    = 10
);
  logic                  sdram_start;
  logic                  sdram_wr_mode;
  logic                  sdram_rd_mode;
  logic                  sdram_init_done;
  logic                  sdram_tx_req;
  logic [DATA_WIDTH-1:0] sdram_tx_data;
  logic                  sdram_rx_valid;
  logic [DATA_WIDTH-1:0] sdram_rx_data;
  logic                  src_ready;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic [LEVEL_W-1:0]    fifo_level;
  logic                  sof;
  logic                  fill_done;
  logic                  overflow;

  modport master (
    output sdram_start, sdram_wr_mode, sdram_rd_mode, sdram_tx_data,
    output src_ready, fifo_wr_en, fifo_wr_data, sof, fill_done, overflow,
    input  sdram_init_done, sdram_tx_req, sdram_rx_valid, sdram_rx_data,
    input  src_data, fifo_level
  );

  modport slave (
    input  sdram_start, sdram_wr_mode, sdram_rd_mode, sdram_tx_data,
    input  src_ready, fifo_wr_en, fifo_wr_data, sof, fill_done, overflow,
    output sdram_init_done, sdram_tx_req, sdram_rx_valid, sdram_rx_data,
    output src_data, fifo_level
  );
endinterface

`default_nettype wire

// File: rtl/sdram_stream_scheduler.sv
//------------------------------------------------------------------------------
// sdram_stream_scheduler : power-up/init, one-shot frame fill, cyclic readout
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sdram_stream_scheduler #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_WORDS = 76800,
  parameter int PWRUP_CYC   = 28600,
  parameter int LEVEL_W     = 10,
  parameter int FIFO_DEPTH  = 512,
  parameter int HIGH_WM     = 480,
  parameter int LOW_WM      = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sdram_stream_scheduler_if.master   bus
);

  localparam int CNT_W = $clog2(FRAME_WORDS);
  localparam int PWR_W = $clog2(PWRUP_CYC);

  localparam logic [CNT_W-1:0]   C_LAST_WORD = CNT_W'(FRAME_WORDS - 1);
  localparam logic [PWR_W-1:0]   C_PWR_LAST  = PWR_W'(PWRUP_CYC - 1);
  localparam logic [LEVEL_W-1:0] C_LVL_FULL  = LEVEL_W'(FIFO_DEPTH);
  localparam logic [LEVEL_W-1:0] C_LVL_HIGH  = LEVEL_W'(HIGH_WM);
  localparam logic [LEVEL_W-1:0] C_LVL_LOW   = LEVEL_W'(LOW_WM);

  typedef enum logic [1:0] {
    PWRUP  = 2'd0,
    INIT   = 2'd1,
    FILL   = 2'd2,
    STREAM = 2'd3
  } state_t;

  // Reset asserts immediately, releases only on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  state_t                state_q, state_d;
  logic [PWR_W-1:0]      pwr_cnt_q, pwr_cnt_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic                  start_q, start_d;
  logic                  wr_mode_q, wr_mode_d;
  logic                  fill_done_q, fill_done_d;
  logic                  rd_gate_q, rd_gate_d;
  logic                  fifo_wr_en_q, fifo_wr_en_d;
  logic [DATA_WIDTH-1:0] fifo_wr_data_q, fifo_wr_data_d;
  logic                  sof_q, sof_d;
  logic                  overflow_q, overflow_d;

  logic w_wr_beat;
  logic w_rx_beat;
  logic w_fifo_full;

  assign w_wr_beat   = (state_q == FILL)   && bus.sdram_tx_req;
  assign w_rx_beat   = (state_q == STREAM) && bus.sdram_rx_valid;
  assign w_fifo_full = (bus.fifo_level == C_LVL_FULL);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q        <= PWRUP;
      pwr_cnt_q      <= '0;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      start_q        <= 1'b0;
      wr_mode_q      <= 1'b0;
      fill_done_q    <= 1'b0;
      rd_gate_q      <= 1'b1;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
      sof_q          <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pwr_cnt_q      <= pwr_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      start_q        <= start_d;
      wr_mode_q      <= wr_mode_d;
      fill_done_q    <= fill_done_d;
      rd_gate_q      <= rd_gate_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_wr_data_q <= fifo_wr_data_d;
      sof_q          <= sof_d;
      overflow_q     <= overflow_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pwr_cnt_d      = pwr_cnt_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    fill_done_d    = fill_done_q;
    rd_gate_d      = rd_gate_q;
    fifo_wr_en_d   = 1'b0;
    fifo_wr_data_d = fifo_wr_data_q;
    sof_d          = 1'b0;
    overflow_d     = overflow_q;

    case (state_q)
      PWRUP: begin
        if (pwr_cnt_q == C_PWR_LAST) state_d = INIT;
        else                         pwr_cnt_d = pwr_cnt_q + 1'b1;
      end
      INIT: begin
        if (bus.sdram_init_done) state_d = FILL;
      end
      FILL: begin
        if (w_wr_beat) begin
          if (wr_cnt_q == C_LAST_WORD) begin
            wr_cnt_d    = '0;
            fill_done_d = 1'b1;
            state_d     = STREAM;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      STREAM: begin
        // A beat into a full FIFO is lost but still occupies its frame slot.
        if (w_rx_beat) begin
          rd_cnt_d = (rd_cnt_q == C_LAST_WORD) ? '0 : rd_cnt_q + 1'b1;
          if (w_fifo_full) begin
            overflow_d = 1'b1;
          end else begin
            fifo_wr_en_d   = 1'b1;
            fifo_wr_data_d = bus.sdram_rx_data;
            sof_d          = (rd_cnt_q == '0);
          end
        end
      end
      default: state_d = PWRUP;
    endcase

    start_d   = (state_d == INIT);
    wr_mode_d = (state_d == FILL);

    // Hysteresis: hold between the watermarks.
    if (bus.fifo_level >= C_LVL_HIGH)     rd_gate_d = 1'b0;
    else if (bus.fifo_level <= C_LVL_LOW) rd_gate_d = 1'b1;
  end

  assign bus.sdram_start   = start_q;
  assign bus.sdram_wr_mode = wr_mode_q;
  assign bus.sdram_rd_mode = (state_q == STREAM) && rd_gate_q;
  assign bus.src_ready     = w_wr_beat;
  assign bus.sdram_tx_data = w_wr_beat ? bus.src_data : '0;
  assign bus.fifo_wr_en    = fifo_wr_en_q;
  assign bus.fifo_wr_data  = fifo_wr_data_q;
  assign bus.sof           = sof_q;
  assign bus.fill_done     = fill_done_q;
  assign bus.overflow      = overflow_q;

endmodule

`default_nettype wire
